if_id_stage: RTL and testbench
==============================

// Module: if_id_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register; direct consumer of BranchBubble from the branch hazard unit.
//  Owns the PC and drives the instruction-memory address.
//  Latches instruction and PC+4 into IF/ID; holds on hazard stalls and flushes on ID-resolved branch/jump redirects.
//  No branch delay slot. Keeps saturating stall/flush counters for performance debug.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset (word aligned)
//  NOP_INSTR 32'h0000_0000  instruction injected into IF/ID on flush/reset
//  CNT_W     16             width of stall_cnt / flush_cnt
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  BranchBubble   in   1      ID branch operands not ready (ex/mem hazard); stall
//  LoadUseBubble  in   1      load-use hazard from ID/EX; stall
//  id_BranchTaken in   1      branch in ID resolved taken (valid only when not stalled)
//  id_BranchTarget in  32     branch target address
//  id_Jump        in   1      J/JAL/JR in ID (valid only when not stalled)
//  id_JumpTarget  in   32     jump target address
//  imem_addr      out  32     instruction-memory address (= PC, combinational read)
//  imem_rdata     in   32     instruction at imem_addr, same cycle
//  id_Instr       out  32     IF/ID instruction
//  id_PC4         out  32     IF/ID PC+4 of id_Instr
//  id_Valid       out  1      1 = id_Instr is a real fetched instruction; 0 = bubble
//  stall_cnt      out  CNT_W  cycles with stall asserted, saturating
//  flush_cnt      out  CNT_W  redirects taken, saturating
// BEHAVIOUR
//  - Reset (rst=1 at edge): PC<=RESET_PC; id_Instr<=NOP_INSTR; id_PC4<=0; id_Valid<=0; counters<=0.
//    rst overrides all other inputs, including mid-stall and mid-redirect.
//  - stall = BranchBubble | LoadUseBubble. Per-edge priority: rst > stall > redirect > normal fetch.
//  - stall=1: PC, id_Instr, id_PC4, id_Valid hold; id_BranchTaken/id_Jump ignored, because branch
//    operands are not final. stall_cnt += 1, saturating at 2^CNT_W-1.
//  - redirect (stall=0, id_Jump|id_BranchTaken): id_Jump wins if both are set.
//    PC<=target with bits[1:0] forced to 0; IF/ID<=NOP_INSTR, id_PC4<=0, id_Valid<=0.
//    This discards the wrong-path fetch. flush_cnt += 1, saturating.
//  - normal: PC<=PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0);
//    id_Instr<=imem_rdata, id_PC4<=PC+4, id_Valid<=1.
//  - imem_addr = PC combinationally; PC bits[1:0] are always 0.
//  - Latency: an instruction at PC appears on id_Instr 1 cycle after PC is presented,
//    plus 1 for each stall cycle.
//  - Taken-branch penalty: exactly 1 bubble. Branch behind a BranchBubble: penalty = stall cycles + 1.
//  - Stall deassert edge: the held instruction is released unchanged, with no duplicate and no drop.
//  - Bubbles flushed into IF/ID do not re-trigger redirects: downstream decodes NOP_INSTR as no branch.
//  - Counters never wrap. They are cleared only by rst.
// TESTING
//  1 rst=1 for 2 clk, then release, imem returns addr as data -> PC 3000,3004,3008;
//    id_Instr follows 1 cycle behind; id_Valid 0 then 1.
//  2 BranchBubble=1 for 3 cycles at PC=3008 -> PC and IF/ID frozen 3 cycles; stall_cnt=3;
//    on release id_Instr=3008 exactly once.
//  3 id_BranchTaken=1, target=32'h3100 (no stall) -> next PC=3100; id_Valid=0 one cycle;
//    next id_Instr=3100; flush_cnt=1.
//  4 id_BranchTaken=1 together with BranchBubble=1 for 2 cycles, then taken with bubble low
//    -> no redirect during stall; redirect to target on 3rd edge.
//  5 id_Jump=1 (target 32'h3203) and id_BranchTaken=1 (3100) together -> PC=3200 (jump wins, aligned).
//  6 CNT_W=4, LoadUseBubble=1 for 20 cycles -> stall_cnt=15 held;
//    rst asserted mid-stall -> all regs at reset values next edge.

Source files
------------

// File: rtl/if_id_stage.sv
// Fetch stage with IF/ID pipeline register: owns the PC and latches fetched instructions.
// Holds on hazard stalls, flushes on ID-resolved redirects, and keeps saturating perf counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchBubble,
    input  logic             LoadUseBubble,
    input  logic             id_BranchTaken,
    input  logic [31:0]      id_BranchTarget,
    input  logic             id_Jump,
    input  logic [31:0]      id_JumpTarget,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      id_Instr,
    output logic [31:0]      id_PC4,
    output logic             id_Valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;

    assign stall    = BranchBubble | LoadUseBubble;
    assign redirect = id_Jump | id_BranchTaken;
    assign pc_plus4 = pc + XLEN'(4);

    // Jump has priority over branch; low bits are dropped to keep the PC word aligned.
    always_comb begin
        redirect_target = id_BranchTarget;
        if (id_Jump) begin
            redirect_target = id_JumpTarget;
        end
        redirect_target[1:0] = 2'b00;
    end

    // PC and IF/ID register: rst > stall > redirect > normal fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= {RESET_PC[XLEN-1:2], 2'b00};
            id_Instr <= NOP_INSTR;
            id_PC4   <= '0;
            id_Valid <= 1'b0;
        end else if (stall) begin
            pc       <= pc;
            id_Instr <= id_Instr;
            id_PC4   <= id_PC4;
            id_Valid <= id_Valid;
        end else if (redirect) begin
            pc       <= redirect_target;
            id_Instr <= NOP_INSTR;
            id_PC4   <= '0;
            id_Valid <= 1'b0;
        end else begin
            pc       <= pc_plus4;
            id_Instr <= imem_rdata;
            id_PC4   <= pc_plus4;
            id_Valid <= 1'b1;
        end
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!stall && redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; instruction memory returns its address as data.
module tb_if_id_stage;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             BranchBubble;
    logic             LoadUseBubble;
    logic             id_BranchTaken;
    logic [31:0]      id_BranchTarget;
    logic             id_Jump;
    logic [31:0]      id_JumpTarget;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      id_Instr;
    logic [31:0]      id_PC4;
    logic             id_Valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int tests_run;
    int tests_failed;

    if_id_stage #(
        .RESET_PC (32'h0000_3000),
        .NOP_INSTR(32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .BranchBubble   (BranchBubble),
        .LoadUseBubble  (LoadUseBubble),
        .id_BranchTaken (id_BranchTaken),
        .id_BranchTarget(id_BranchTarget),
        .id_Jump        (id_Jump),
        .id_JumpTarget  (id_JumpTarget),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_Instr       (id_Instr),
        .id_PC4         (id_PC4),
        .id_Valid       (id_Valid),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign imem_rdata = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stage(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid);
        check({tag, ".pc"},    imem_addr, pc);
        check({tag, ".instr"}, id_Instr,  instr);
        check({tag, ".pc4"},   id_PC4,    pc4);
        check({tag, ".valid"}, 32'(id_Valid), 32'(valid));
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b1;
        BranchBubble    = 1'b0;
        LoadUseBubble   = 1'b0;
        id_BranchTaken  = 1'b0;
        id_BranchTarget = 32'h0;
        id_Jump         = 1'b0;
        id_JumpTarget   = 32'h0;

        // Reset held for two edges
        step();
        step();
        check_stage("reset", 32'h3000, 32'h0, 32'h0, 1'b0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);

        // Sequential fetch
        rst = 1'b0;
        step();
        check_stage("fetch1", 32'h3004, 32'h3000, 32'h3004, 1'b1);
        step();
        check_stage("fetch2", 32'h3008, 32'h3004, 32'h3008, 1'b1);

        // BranchBubble stall for 3 cycles at PC=3008
        BranchBubble = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_stage("bbstall", 32'h3008, 32'h3004, 32'h3008, 1'b1);
        end
        check("bbstall.stall_cnt", 32'(stall_cnt), 32'd3);
        BranchBubble = 1'b0;
        step();
        check_stage("release", 32'h300C, 32'h3008, 32'h300C, 1'b1);
        step();
        check_stage("release2", 32'h3010, 32'h300C, 32'h3010, 1'b1);

        // Taken branch, no stall: one bubble
        id_BranchTaken  = 1'b1;
        id_BranchTarget = 32'h3100;
        step();
        check_stage("br", 32'h3100, 32'h0, 32'h0, 1'b0);
        check("br.flush_cnt", 32'(flush_cnt), 32'd1);
        id_BranchTaken = 1'b0;
        step();
        check_stage("br.tgt", 32'h3104, 32'h3100, 32'h3104, 1'b1);

        // Taken branch behind BranchBubble: ignored while stalled
        id_BranchTaken  = 1'b1;
        id_BranchTarget = 32'h3180;
        BranchBubble    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_stage("brstall", 32'h3104, 32'h3100, 32'h3104, 1'b1);
            check("brstall.flush_cnt", 32'(flush_cnt), 32'd1);
        end
        check("brstall.stall_cnt", 32'(stall_cnt), 32'd5);
        BranchBubble = 1'b0;
        step();
        check_stage("brstall.redir", 32'h3180, 32'h0, 32'h0, 1'b0);
        check("brstall.flush_cnt2", 32'(flush_cnt), 32'd2);
        id_BranchTaken = 1'b0;
        step();
        check_stage("brstall.tgt", 32'h3184, 32'h3180, 32'h3184, 1'b1);

        // Jump and branch together: jump wins, target aligned
        id_Jump         = 1'b1;
        id_JumpTarget   = 32'h3203;
        id_BranchTaken  = 1'b1;
        id_BranchTarget = 32'h3100;
        step();
        check_stage("jmp", 32'h3200, 32'h0, 32'h0, 1'b0);
        check("jmp.flush_cnt", 32'(flush_cnt), 32'd3);
        id_Jump        = 1'b0;
        id_BranchTaken = 1'b0;
        step();
        check_stage("jmp.tgt", 32'h3204, 32'h3200, 32'h3204, 1'b1);

        // PC wrap at top of address space
        id_Jump       = 1'b1;
        id_JumpTarget = 32'hFFFF_FFFF;
        step();
        check_stage("wrapjmp", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        id_Jump = 1'b0;
        step();
        check_stage("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // LoadUseBubble for 20 cycles: stall_cnt saturates at 15
        LoadUseBubble = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat.stall_cnt", 32'(stall_cnt), 32'd15);
        check_stage("sat", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
        step();
        check("sat.stall_cnt2", 32'(stall_cnt), 32'd15);

        // Reset mid-stall with a pending redirect
        rst            = 1'b1;
        id_BranchTaken = 1'b1;
        id_BranchTarget = 32'h3100;
        step();
        check_stage("rststall", 32'h3000, 32'h0, 32'h0, 1'b0);
        check("rststall.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rststall.flush_cnt", 32'(flush_cnt), 32'd0);
        rst            = 1'b0;
        LoadUseBubble  = 1'b0;
        id_BranchTaken = 1'b0;
        step();
        check_stage("postrst", 32'h3004, 32'h3000, 32'h3004, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
